// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle LEGv8-subset control FSM with retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] instr_op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        reg2loc,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] LD_WB    = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] EXEC_I   = 4'd7;
  localparam logic [3:0] ALU_WB   = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] HALT     = 4'd10;

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic [31:0] retired_q;
  logic        is_ldur;
  logic        is_stur;
  logic        is_cbz;
  logic        is_imm;
  logic        is_rtype;
  logic        retire_now;
  logic        pc_write_raw;
  logic        ir_write_raw;
  logic        reg_write_raw;
  logic        mem_read_raw;
  logic        mem_write_raw;

  assign is_ldur  = (instr_op == 11'b11111000010);
  assign is_stur  = (instr_op == 11'b11111000000);
  assign is_cbz   = (instr_op[10:3] == 8'b10110100);
  assign is_imm   = (instr_op[10:1] == 10'b1001000100) || (instr_op[10:1] == 10'b1101000100);
  assign is_rtype = (instr_op == 11'b10001011000) || (instr_op == 11'b11001011000) ||
                    (instr_op == 11'b10001010000) || (instr_op == 11'b10101010000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (is_ldur || is_stur) state_d = MEM_ADDR;
        else if (is_cbz)        state_d = BRANCH;
        else if (is_imm)        state_d = EXEC_I;
        else if (is_rtype)      state_d = EXEC_R;
        else                    state_d = HALT;
      end
      MEM_ADDR: state_d = is_ldur ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = LD_WB;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      EXEC_R:   state_d = ALU_WB;
      EXEC_I:   state_d = ALU_WB;
      LD_WB:    state_d = FETCH;
      ALU_WB:   state_d = FETCH;
      BRANCH:   state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
  end

  // An instruction completes on every transition back into FETCH except out of HALT.
  assign retire_now = (state_q == LD_WB) || (state_q == ALU_WB) || (state_q == BRANCH) ||
                      ((state_q == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire_now) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    mem_to_reg    = 1'b0;
    pc_src        = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
      end
      LD_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEM_WR: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      ALU_WB:   reg_write_raw = 1'b1;
      BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b01;
        pc_src       = 1'b1;
        pc_write_raw = zero;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so an abandoned instruction never writes anything.
  assign pc_write  = pc_write_raw  & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign mem_read  = mem_read_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;

  assign reg2loc = (state_q != FETCH) && (is_stur || is_cbz);
  assign illegal = (state_q == HALT);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed-vector self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] instr_op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write;
  logic        i_or_d, alu_src_a, mem_to_reg, pc_src, reg2loc, illegal;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .reg2loc(reg2loc),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field order: pcw irw rw mr mw iod asa asb aop m2r psrc r2l ill state
  function automatic logic [31:0] cw(logic pcw, logic irw, logic rw, logic mr, logic mw,
                                     logic iod, logic asa, logic [1:0] asb, logic [1:0] aop,
                                     logic m2r, logic psrc, logic r2l, logic ill,
                                     logic [3:0] st);
    return {13'd0, pcw, irw, rw, mr, mw, iod, asa, asb, aop, m2r, psrc, r2l, ill, st};
  endfunction

  function automatic logic [31:0] obs();
    return {13'd0, pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, alu_src_a,
            alu_src_b, alu_op, mem_to_reg, pc_src, reg2loc, illegal, state};
  endfunction

  task automatic step(input logic rdy, input logic z);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_op = 11'd0; zero = 1'b0; mem_ready = 1'b0;

    @(negedge clk); #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_strobes", obs(), cw(0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    reset = 1'b0; #1;
    check("fetch_wait", obs(), cw(0,0,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));

    // ADD: 0,1,6,8,0
    instr_op = OP_ADD;
    step(1, 0); check("add_fetch", obs(), cw(1,1,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    step(0, 0); check("add_decode", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,4'd1));
    step(0, 0); check("add_exec_r", obs(), cw(0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0,4'd6));
    step(0, 0); check("add_alu_wb", obs(), cw(0,0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,4'd8));
    check("add_ret_before", retired, 32'd0);
    step(0, 0); check("add_back", obs(), cw(0,0,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    check("add_ret", retired, 32'd1);

    // LDUR with three wait cycles in MEM_RD
    instr_op = OP_LDUR;
    step(1, 0); check("ld_fetch", obs(), cw(1,1,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    step(0, 0); check("ld_decode", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,4'd1));
    step(0, 0); check("ld_addr", obs(), cw(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,4'd2));
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0);
      check("ld_mem_rd", obs(), cw(0,0,0,1,0,1,0,2'b00,2'b00,0,0,0,0,4'd3));
    end
    step(0, 0); check("ld_wb", obs(), cw(0,0,1,0,0,0,0,2'b00,2'b00,1,0,0,0,4'd4));
    step(0, 0); check("ld_back", {28'd0, state}, 32'd0);
    check("ld_ret", retired, 32'd2);

    // STUR: reg2loc set from DECODE onward
    instr_op = OP_STUR;
    step(1, 0); check("st_fetch", obs(), cw(1,1,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    step(0, 0); check("st_decode", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,4'd1));
    step(0, 0); check("st_addr", obs(), cw(0,0,0,0,0,0,1,2'b10,2'b00,0,0,1,0,4'd2));
    step(1, 0); check("st_mem_wr", obs(), cw(0,0,0,0,1,1,0,2'b00,2'b00,0,0,1,0,4'd5));
    step(0, 0); check("st_back", obs(), cw(0,0,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));
    check("st_ret", retired, 32'd3);

    // CBZ taken and not taken
    instr_op = OP_CBZ;
    step(1, 0); step(0, 0);
    check("cbz_decode", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,4'd1));
    step(0, 1); check("cbz_taken", obs(), cw(1,0,0,0,0,0,1,2'b00,2'b01,0,1,1,0,4'd9));
    step(0, 0); check("cbz_t_ret", retired, 32'd4);
    step(1, 0); step(0, 0);
    step(0, 0); check("cbz_not_taken", obs(), cw(0,0,0,0,0,0,1,2'b00,2'b01,0,1,1,0,4'd9));
    step(0, 0); check("cbz_nt_ret", retired, 32'd5);

    // ADDI
    instr_op = OP_ADDI;
    step(1, 0); step(0, 0);
    step(0, 0); check("addi_exec_i", obs(), cw(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0,4'd7));
    step(0, 0); check("addi_alu_wb", obs(), cw(0,0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,4'd8));
    step(0, 0); check("addi_ret", retired, 32'd6);

    // Reset while STUR waits in MEM_WR
    instr_op = OP_STUR;
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); check("rw_mem_wr", obs(), cw(0,0,0,0,1,1,0,2'b00,2'b00,0,0,1,0,4'd5));
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
    check("rw_wr_gated", {31'd0, mem_write}, 32'd0);
    check("rw_state_hold", {28'd0, state}, 32'd5);
    @(negedge clk); #1;
    check("rw_state", {28'd0, state}, 32'd0);
    check("rw_ret", retired, 32'd0);
    reset = 1'b0;

    // Illegal opcode -> HALT held for 10 clocks
    instr_op = 11'd0;
    step(1, 0); step(0, 0);
    step(0, 0); check("halt_entry", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,1,4'd10));
    for (int i = 0; i < 10; i++) step(1, 0);
    check("halt_held", obs(), cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,1,4'd10));
    check("halt_ret", retired, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("halt_reset", {27'd0, illegal, state}, 32'd0);
    reset = 1'b0; mem_ready = 1'b0;

    // Counter wrap: preset near the top while idling in FETCH
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    #1 check("wrap_preset", retired, 32'hFFFF_FFFE);
    instr_op = OP_CBZ;
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    check("wrap_max", retired, 32'hFFFF_FFFF);
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    check("wrap_zero", retired, 32'd0);
    check("wrap_state", obs(), cw(0,0,0,1,0,0,0,2'b01,2'b00,0,0,0,0,4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
